square_freq_meter: RTL and testbench

//  Receive-side counterpart of the square-wave generator: takes the 6-bit sample stream
//  (0 / +60 levels, LUT length 24000, phase step Fo) and recovers the period and step.

---
 rtl/square_freq_meter.sv | 189 ++++++++++++++++++
 tb/tb_square_freq_meter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_freq_meter.sv
// Square-wave frequency meter: slices a 6-bit sample stream, measures samples between rising
// edges and divides LUT_LEN by that period. Define SQM_HYST_EN for a hysteresis slicer.
module square_freq_meter #(
    parameter int LUT_LEN    = 24000,
    parameter int THRESH     = 30,
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 2
`ifdef SQM_HYST_EN
    ,
    parameter int HYST       = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       sample_in,
    input  logic             sample_en,
    output logic [CNT_W-1:0] period_out,
    output logic [8:0]       fo_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             overrun,
    output logic             timeout
);

    localparam int               ITW       = $clog2(CNT_W + 1);
    localparam logic [ITW-1:0]   C_ITERS   = ITW'(CNT_W);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_LUT     = CNT_W'(LUT_LEN);
    localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(MIN_PERIOD);
`ifdef SQM_HYST_EN
    localparam logic [5:0]       C_HI      = 6'(THRESH + HYST);
    localparam logic [5:0]       C_LO      = 6'(THRESH - HYST);
`else
    localparam logic [5:0]       C_TH      = 6'(THRESH);
`endif

    typedef enum logic {
        S_IDLE,
        S_ARMED
    } state_t;

    state_t             r_state;
    logic               r_level;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_timeout;
    logic               r_locked;
    logic               r_seenOne;
    logic               r_overrun;

    logic               r_divBusy;
    logic [ITW-1:0]     r_it;
    logic [CNT_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_quo;
    logic [CNT_W-1:0]   r_div;
    logic [CNT_W-1:0]   r_period;
    logic [8:0]         r_fo;
    logic               r_measValid;

    logic               w_levelNext;
    logic               w_rise;
    logic               w_accept;
    logic               w_start;
    logic               w_overrunSet;
    logic               w_divDone;
    logic [CNT_W:0]     w_shift;
    logic               w_fits;
    logic [CNT_W-1:0]   w_remNext;

    always_comb begin
        w_levelNext = r_level;
`ifdef SQM_HYST_EN
        if (r_level) begin
            if (sample_in < C_LO) begin
                w_levelNext = 1'b0;
            end
        end else if (sample_in >= C_HI) begin
            w_levelNext = 1'b1;
        end
`else
        w_levelNext = (sample_in >= C_TH);
`endif
    end

    assign w_rise       = sample_en && !r_level && w_levelNext;
    assign w_accept     = (r_state == S_ARMED) && w_rise && (r_cnt >= C_MIN);
    assign w_start      = w_accept && !r_divBusy;
    assign w_overrunSet = w_accept && r_divBusy;
    assign w_divDone    = r_divBusy && (r_it == C_ITERS);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_level <= 1'b0;
        end else if (sample_en) begin
            r_level <= w_levelNext;
        end
    end

    // Period counter and status flags; a timeout returns to IDLE so the next edge only re-arms.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_locked  <= 1'b0;
            r_seenOne <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_divDone) begin
                r_seenOne <= 1'b1;
                if (r_seenOne) begin
                    r_locked <= 1'b1;
                end
            end
            if (w_overrunSet) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        r_cnt     <= CNT_W'(1);
                        r_timeout <= 1'b0;
                        r_state   <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (sample_en) begin
                        if (w_rise) begin
                            r_cnt <= CNT_W'(1);
                        end else if (r_cnt == C_CNT_MAX) begin
                            r_timeout <= 1'b1;
                            r_locked  <= 1'b0;
                            r_seenOne <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_shift   = {r_rem, r_quo[CNT_W-1]};
    assign w_fits    = (w_shift >= {1'b0, r_div});
    assign w_remNext = w_fits ? CNT_W'(w_shift - {1'b0, r_div}) : w_shift[CNT_W-1:0];

    // Restoring divider: load on the edge, CNT_W iterations, then one cycle to publish.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_divBusy   <= 1'b0;
            r_it        <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_period    <= '0;
            r_fo        <= '0;
            r_measValid <= 1'b0;
        end else begin
            r_measValid <= 1'b0;
            if (w_start) begin
                r_divBusy <= 1'b1;
                r_it      <= '0;
                r_rem     <= '0;
                r_quo     <= C_LUT;
                r_div     <= r_cnt;
            end else if (r_divBusy) begin
                if (w_divDone) begin
                    r_divBusy   <= 1'b0;
                    r_period    <= r_div;
                    r_fo        <= (|r_quo[CNT_W-1:9]) ? 9'h1FF : r_quo[8:0];
                    r_measValid <= 1'b1;
                end else begin
                    r_rem <= w_remNext;
                    r_quo <= {r_quo[CNT_W-2:0], w_fits};
                    r_it  <= r_it + 1'b1;
                end
            end
        end
    end

    assign period_out = r_period;
    assign fo_out     = r_fo;
    assign meas_valid = r_measValid;
    assign locked     = r_locked;
    assign overrun    = r_overrun;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_square_freq_meter.sv
// Bench for square_freq_meter: a sample-level reference model feeds a scoreboard of expected
// measurements; scenario tasks check the status flags directly.
module tb_square_freq_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  sample_in;
    logic        sample_en;
    logic [15:0] period_out;
    logic [8:0]  fo_out;
    logic        meas_valid;
    logic        locked;
    logic        overrun;
    logic        timeout;

    always #5 clk = ~clk;

    square_freq_meter dut (
        .clk        (clk),
        .reset      (reset),
        .sample_in  (sample_in),
        .sample_en  (sample_en),
        .period_out (period_out),
        .fo_out     (fo_out),
        .meas_valid (meas_valid),
        .locked     (locked),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    typedef struct {
        logic [15:0] period;
        logic [8:0]  fo;
        int          due;
    } exp_t;

    exp_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cycle      = 0;
    int   busyUntil  = 0;
    logic mLevel     = 1'b0;
    logic mArmed     = 1'b0;
    int   mCnt       = 0;

    // One clock: drive at the falling edge, advance the reference model at the rising edge.
    task automatic clockOne(input logic [5:0] v, input logic en, input logic rst);
        int   p;
        int   q;
        logic newLvl;
        logic rise;
        exp_t e;
        @(negedge clk);
        sample_in = v;
        sample_en = en;
        reset     = rst;
        @(posedge clk);
        cycle++;
        if (rst) begin
            mLevel = 1'b0; mArmed = 1'b0; mCnt = 0; busyUntil = 0;
            expQ.delete();
        end else if (en) begin
`ifdef SQM_HYST_EN
            if (mLevel) newLvl = (v >= 6'd22);
            else        newLvl = (v >= 6'd38);
`else
            newLvl = (v >= 6'd30);
`endif
            rise   = !mLevel && newLvl;
            mLevel = newLvl;
            if (!mArmed) begin
                if (rise) begin mArmed = 1'b1; mCnt = 1; end
            end else if (rise) begin
                p    = mCnt;
                mCnt = 1;
                if (p >= 2 && cycle > busyUntil) begin
                    q        = 24000 / p;
                    e.period = 16'(p);
                    e.fo     = (q > 511) ? 9'd511 : 9'(q);
                    e.due    = cycle + 17;
                    expQ.push_back(e);
                    busyUntil = cycle + 17;
                end
            end else if (mCnt == 65535) begin
                mArmed = 1'b0;
            end else begin
                mCnt++;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clockOne(6'($urandom_range(0, 63)), 1'b0, 1'b0);
    endtask

    task automatic hold(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) clockOne(v, 1'b1, 1'b0);
    endtask

    task automatic pulses(input int hi, input int lo, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < lo; i++) begin idle(gap); clockOne(6'd0, 1'b1, 1'b0); end
            for (int i = 0; i < hi; i++) begin idle(gap); clockOne(6'd60, 1'b1, 1'b0); end
        end
    endtask

    task automatic doReset();
        clockOne(6'd0, 1'b0, 1'b1);
        clockOne(6'd0, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (meas_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                compared++; mismatched++;
                $display("[TB] FAIL unexpected_meas_valid: observed pulse period_out=%0d fo_out=%0d at cycle %0d, expected none", period_out, fo_out, cycle);
            end else begin
                e = expQ.pop_front();
                compared += 3;
                if (period_out !== e.period) begin mismatched++; $display("[TB] FAIL sb_period: observed %0d, expected %0d", period_out, e.period); end
                if (fo_out !== e.fo) begin mismatched++; $display("[TB] FAIL sb_fo: observed %0d, expected %0d", fo_out, e.fo); end
                if (cycle !== e.due) begin mismatched++; $display("[TB] FAIL sb_latency: observed cycle %0d, expected cycle %0d", cycle, e.due); end
            end
        end else if (expQ.size() > 0 && expQ[0].due < cycle) begin
            e = expQ.pop_front();
            compared++; mismatched++;
            $display("[TB] FAIL sb_missing: observed no meas_valid by cycle %0d, expected one at cycle %0d", cycle, e.due);
        end
    end

    task automatic test_reset();
        doReset();
        compared += 6;
        if (period_out !== 16'd0) begin mismatched++; $display("[TB] FAIL rst_period: observed %0d, expected 0", period_out); end
        if (fo_out !== 9'd0) begin mismatched++; $display("[TB] FAIL rst_fo: observed %0d, expected 0", fo_out); end
        if (meas_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid: observed %0b, expected 0", meas_valid); end
        if (locked !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_locked: observed %0b, expected 0", locked); end
        if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_overrun: observed %0b, expected 0", overrun); end
        if (timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_timeout: observed %0b, expected 0", timeout); end
    endtask

    task automatic test_basic();
        doReset();
        pulses(120, 120, 2, 0);
        idle(20);
        compared += 3;
        if (locked !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_locked_first: observed %0b, expected 0", locked); end
        if (period_out !== 16'd240) begin mismatched++; $display("[TB] FAIL basic_period: observed %0d, expected 240", period_out); end
        if (fo_out !== 9'd100) begin mismatched++; $display("[TB] FAIL basic_fo: observed %0d, expected 100", fo_out); end
        pulses(120, 120, 1, 0);
        idle(20);
        compared++;
        if (locked !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_locked_second: observed %0b, expected 1", locked); end
    endtask

    task automatic test_boundary();
        doReset();
        pulses(12000, 12000, 2, 0);
        idle(20);
        compared += 2;
        if (period_out !== 16'd24000) begin mismatched++; $display("[TB] FAIL bnd_period_long: observed %0d, expected 24000", period_out); end
        if (fo_out !== 9'd1) begin mismatched++; $display("[TB] FAIL bnd_fo_long: observed %0d, expected 1", fo_out); end
        pulses(1, 1, 1, 0);
        idle(20);
        pulses(1, 1, 1, 0);
        idle(20);
        compared += 3;
        if (period_out !== 16'd2) begin mismatched++; $display("[TB] FAIL bnd_period_short: observed %0d, expected 2", period_out); end
        if (fo_out !== 9'd511) begin mismatched++; $display("[TB] FAIL bnd_fo_clamp: observed %0d, expected 511", fo_out); end
        if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL bnd_overrun: observed %0b, expected 0", overrun); end
    endtask

    task automatic test_timeout();
        doReset();
        pulses(20, 20, 3, 0);
        hold(6'd60, 65515);
        compared += 2;
        if (timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL to_early: observed %0b, expected 0", timeout); end
        if (locked !== 1'b1) begin mismatched++; $display("[TB] FAIL to_locked_before: observed %0b, expected 1", locked); end
        hold(6'd60, 1);
        compared += 2;
        if (timeout !== 1'b1) begin mismatched++; $display("[TB] FAIL to_set: observed %0b, expected 1", timeout); end
        if (locked !== 1'b0) begin mismatched++; $display("[TB] FAIL to_locked_after: observed %0b, expected 0", locked); end
        hold(6'd0, 1);
        hold(6'd60, 1);
        idle(20);
        compared += 2;
        if (timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL to_clear: observed %0b, expected 0", timeout); end
        if (locked !== 1'b0) begin mismatched++; $display("[TB] FAIL to_rearm_locked: observed %0b, expected 0", locked); end
    endtask

    task automatic test_overrun();
        doReset();
        pulses(20, 20, 3, 0);
        idle(20);
        compared++;
        if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL ovr_pre: observed %0b, expected 0", overrun); end
        pulses(3, 2, 6, 0);
        idle(20);
        compared += 2;
        if (overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_set: observed %0b, expected 1", overrun); end
        if (locked !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_locked: observed %0b, expected 1", locked); end
        pulses(3, 2, 1, 0);
        idle(20);
        compared += 3;
        if (period_out !== 16'd5) begin mismatched++; $display("[TB] FAIL ovr_period: observed %0d, expected 5", period_out); end
        if (fo_out !== 9'd511) begin mismatched++; $display("[TB] FAIL ovr_fo: observed %0d, expected 511", fo_out); end
        if (overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL ovr_sticky: observed %0b, expected 1", overrun); end
    endtask

    task automatic test_hysteresis();
        doReset();
        for (int k = 0; k < 3; k++) begin
            hold(6'd0, 120);
            for (int i = 0; i < 120; i++) begin
                if (i >= 40 && i < 80) hold(((i % 2) != 0) ? 6'd35 : 6'd25, 1);
                else                   hold(6'd60, 1);
            end
        end
        idle(20);
`ifdef SQM_HYST_EN
        compared += 3;
        if (period_out !== 16'd240) begin mismatched++; $display("[TB] FAIL hyst_period: observed %0d, expected 240", period_out); end
        if (fo_out !== 9'd100) begin mismatched++; $display("[TB] FAIL hyst_fo: observed %0d, expected 100", fo_out); end
        if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL hyst_overrun: observed %0b, expected 0", overrun); end
`else
        compared++;
        if (overrun !== 1'b1) begin mismatched++; $display("[TB] FAIL nohyst_overrun: observed %0b, expected 1", overrun); end
`endif
    endtask

    task automatic test_reset_mid_divide();
        int seen;
        doReset();
        pulses(120, 120, 2, 0);
        idle(20);
        hold(6'd0, 120);
        hold(6'd60, 5);
        doReset();
        compared += 4;
        if (period_out !== 16'd0) begin mismatched++; $display("[TB] FAIL mid_period: observed %0d, expected 0", period_out); end
        if (fo_out !== 9'd0) begin mismatched++; $display("[TB] FAIL mid_fo: observed %0d, expected 0", fo_out); end
        if (locked !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_locked: observed %0b, expected 0", locked); end
        if (overrun !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_overrun: observed %0b, expected 0", overrun); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            clockOne(6'd60, 1'b0, 1'b0);
            if (meas_valid === 1'b1) seen++;
        end
        compared++;
        if (seen !== 0) begin mismatched++; $display("[TB] FAIL mid_no_valid: observed %0d pulses, expected 0", seen); end
        pulses(20, 20, 3, 0);
        idle(20);
        compared += 3;
        if (locked !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_relock: observed %0b, expected 1", locked); end
        if (period_out !== 16'd40) begin mismatched++; $display("[TB] FAIL mid_period_after: observed %0d, expected 40", period_out); end
        if (fo_out !== 9'd511) begin mismatched++; $display("[TB] FAIL mid_fo_after: observed %0d, expected 511", fo_out); end
    endtask

    task automatic test_slow_strobe();
        doReset();
        pulses(120, 120, 2, 3);
        idle(20);
        compared += 2;
        if (period_out !== 16'd240) begin mismatched++; $display("[TB] FAIL slow_period: observed %0d, expected 240", period_out); end
        if (fo_out !== 9'd100) begin mismatched++; $display("[TB] FAIL slow_fo: observed %0d, expected 100", fo_out); end
    endtask

    initial begin : watchdog
        #1500000;
        $display("[TB] FAIL watchdog: observed no completion by cycle %0d, expected finish", cycle);
        $fatal(1, "[TB] time limit");
    end

    initial begin
        reset     = 1'b1;
        sample_in = 6'd0;
        sample_en = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_timeout();
        test_overrun();
        test_hysteresis();
        test_reset_mid_divide();
        test_slow_strobe();
        idle(25);
        compared++;
        if (expQ.size() !== 0) begin mismatched++; $display("[TB] FAIL sb_drain: observed %0d pending, expected 0", expQ.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
